max_pool_2x2: RTL and testbench

- Downstream consumer of the pooling line-buffer controller.
- Takes the 2x2 window of signed fixed-point conv results presented each cycle on the window bus and applies 2x2 stride-2 max pooling.
- Discards windows at odd column and odd row positions.
- Emits one pooled value per kept window through a 2-stage comparator pipeline, plus row-last and frame-done pulses for the next stage (fully-connected input buffer).

---
 rtl/max_pool_2x2_if.sv | 22 ++
 rtl/max_pool_2x2.sv | 100 ++++++++++
 tb/tb_max_pool_2x2.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/max_pool_2x2_if.sv
// Window-in / pooled-out bus between the line-buffer controller, max_pool_2x2
// and the fully-connected input buffer.
interface max_pool_2x2_if #(
  parameter int W = 13
);
  logic [4*W-1:0] pool_input_data;
  logic           pool_input_data_valid;
  logic [W-1:0]   o_pooled_data;
  logic           o_pooled_valid;
  logic           o_row_last;
  logic           o_frame_done;

  modport master (
    output pool_input_data, pool_input_data_valid,
    input  o_pooled_data, o_pooled_valid, o_row_last, o_frame_done
  );

  modport slave (
    input  pool_input_data, pool_input_data_valid,
    output o_pooled_data, o_pooled_valid, o_row_last, o_frame_done
  );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling with a 2-stage comparator pipeline.
// Define POOL_RELU_EN to clamp negative pooled results to zero inside stage 2.
module max_pool_2x2 #(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int LINE_WIDTH       = 512,
  parameter int FRAME_ROWS       = 512
) (
  input  logic           i_clk,
  input  logic           i_rst,
  max_pool_2x2_if.slave  pif
);
  localparam int W  = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int CW = $clog2(LINE_WIDTH);
  localparam int RW = $clog2(FRAME_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0] COL_PEN  = CW'(LINE_WIDTH - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_ROWS - 1);
  localparam logic [RW-1:0] ROW_PEN  = RW'(FRAME_ROWS - 2);

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic signed [W-1:0] r0c0, r0c1, r1c0, r1c1;
  logic signed [W-1:0] m0_q, m0_d, m1_q, m1_d, mx;
  logic signed [W-1:0] data_q, data_d;
  logic v1_q, v1_d, last1_q, last1_d, frame1_q, frame1_d;
  logic vld_q, row_last_q, frame_done_q;
  logic keep;

  assign r0c0 = pif.pool_input_data[W-1:0];
  assign r0c1 = pif.pool_input_data[2*W-1:W];
  assign r1c0 = pif.pool_input_data[3*W-1:2*W];
  assign r1c1 = pif.pool_input_data[4*W-1:3*W];

  assign keep = pif.pool_input_data_valid & ~col_cnt_q[0] & ~row_cnt_q[0];

  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (pif.pool_input_data_valid) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end
    end
  end

  // Stage 1: row-wise max; operands only load on kept windows.
  always_comb begin
    m0_d     = keep ? ((r0c0 >= r0c1) ? r0c0 : r0c1) : m0_q;
    m1_d     = keep ? ((r1c0 >= r1c1) ? r1c0 : r1c1) : m1_q;
    v1_d     = keep;
    last1_d  = keep && (col_cnt_q == COL_PEN);
    frame1_d = last1_d && (row_cnt_q == ROW_PEN);
  end

  // Stage 2: column-wise max; output data holds between pooled values.
  always_comb begin
    mx = (m0_q >= m1_q) ? m0_q : m1_q;
`ifdef POOL_RELU_EN
    if (mx[W-1]) mx = '0;
`endif
    data_d = v1_q ? mx : data_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      m0_q         <= '0;
      m1_q         <= '0;
      v1_q         <= 1'b0;
      last1_q      <= 1'b0;
      frame1_q     <= 1'b0;
      data_q       <= '0;
      vld_q        <= 1'b0;
      row_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      m0_q         <= m0_d;
      m1_q         <= m1_d;
      v1_q         <= v1_d;
      last1_q      <= last1_d;
      frame1_q     <= frame1_d;
      data_q       <= data_d;
      vld_q        <= v1_q;
      row_last_q   <= last1_q;
      frame_done_q <= frame1_q;
    end
  end

  assign pif.o_pooled_data  = data_q;
  assign pif.o_pooled_valid = vld_q;
  assign pif.o_row_last     = row_last_q;
  assign pif.o_frame_done   = frame_done_q;
endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2 on an 8x4 window frame; honours POOL_RELU_EN.
module tb_max_pool_2x2;
  localparam int W  = 13;
  localparam int LW = 8;
  localparam int FR = 4;

  logic i_clk = 1'b0;
  logic i_rst;
  int   cyc = 0;
  int   total = 0;
  int   pass  = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         rl;
    logic         fd;
    int           cyc;
  } exp_t;
  exp_t q[$];

  int keep_n[8] = '{0, 2, 4, 6, 16, 18, 20, 22};

  max_pool_2x2_if #(.W(W)) pif ();

  max_pool_2x2 #(
    .INTEGER_BITS(9), .FIXED_POINT_BITS(4), .LINE_WIDTH(LW), .FRAME_ROWS(FR)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .pif(pif)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] relu(input logic signed [W-1:0] x);
`ifdef POOL_RELU_EN
    return x[W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Window whose max is n, with the max rotated through the four positions.
  function automatic logic [4*W-1:0] mkwin(input int n);
    logic [4*W-1:0] w;
    int p = n % 4;
    int j = 0;
    w = '0;
    for (int s = 0; s < 4; s++) begin
      if (s == p) w[s*W +: W] = W'(n);
      else begin
        w[s*W +: W] = W'(n - 1 - j);
        j++;
      end
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  task automatic send(input logic [4*W-1:0] win, input bit push,
                      input logic [W-1:0] ed, input bit rl, input bit fd);
    exp_t e;
    @(posedge i_clk); #1;
    pif.pool_input_data       = win;
    pif.pool_input_data_valid = 1'b1;
    if (push) begin
      e.data = ed; e.rl = rl; e.fd = fd; e.cyc = cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      pif.pool_input_data_valid = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    @(posedge i_clk); #1;
    pif.pool_input_data_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk("rst_data", pif.o_pooled_data, '0);
    chk("rst_valid", W'(pif.o_pooled_valid), '0);
    chk("rst_flags", W'({pif.o_row_last, pif.o_frame_done}), '0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic run_frame(input bit gapped);
    int k = 0;
    for (int n = 0; n < LW*FR; n++) begin
      if (gapped) idle($urandom_range(0, 2));
      if (k < 8 && n == keep_n[k]) begin
        send(mkwin(n), 1'b1, relu(W'(n)), (k == 3) || (k == 7), k == 7);
        k++;
      end else begin
        send(mkwin(n), 1'b0, '0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          total++;
          $display("FAIL missing_out exp_data=%h exp_cyc=%0d now=%0d", e.data, e.cyc, cyc);
        end
        if (pif.o_pooled_valid) begin
          total++;
          if (q.size() == 0) begin
            $display("FAIL unexpected_out data=%h cyc=%0d", pif.o_pooled_data, cyc);
          end else begin
            e = q.pop_front();
            if (pif.o_pooled_data === e.data && pif.o_row_last === e.rl &&
                pif.o_frame_done === e.fd && cyc == e.cyc)
              pass++;
            else
              $display("FAIL out act=%h/rl%b/fd%b@%0d exp=%h/rl%b/fd%b@%0d",
                       pif.o_pooled_data, pif.o_row_last, pif.o_frame_done, cyc,
                       e.data, e.rl, e.fd, e.cyc);
          end
        end else if (pif.o_row_last || pif.o_frame_done) begin
          total++;
          $display("FAIL flag_without_valid rl=%b fd=%b cyc=%0d",
                   pif.o_row_last, pif.o_frame_done, cyc);
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    pif.pool_input_data       = '0;
    pif.pool_input_data_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("init_data", pif.o_pooled_data, '0);
    chk("init_valid", W'(pif.o_pooled_valid), '0);
    chk("init_flags", W'({pif.o_row_last, pif.o_frame_done}), '0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Single kept window: r0c0=5 r0c1=-3 r1c0=17 r1c1=2 -> 17.
    send({W'(2), W'(17), W'(-3), W'(5)}, 1'b1, relu(W'(17)), 1'b0, 1'b0);
    idle(4);
    reset_pulse();

    // Full contiguous frame.
    run_frame(1'b0);
    idle(4);
    reset_pulse();

    // Most negative value, then small negatives; odd column discarded between.
    send({4{13'h1000}}, 1'b1, relu(13'h1000), 1'b0, 1'b0);
    send({W'(100), W'(100), W'(100), W'(100)}, 1'b0, '0, 1'b0, 1'b0);
    send({W'(-4), W'(-3), W'(-2), W'(-1)}, 1'b1, relu(W'(-1)), 1'b0, 1'b0);
    idle(4);
    reset_pulse();

    // Gapped valid.
    run_frame(1'b1);
    idle(4);
    reset_pulse();

    // Two frames back to back.
    run_frame(1'b0);
    run_frame(1'b0);
    idle(4);
    reset_pulse();

    // Reset while window 4 (kept) sits in stage 1.
    for (int n = 0; n < 5; n++)
      send(mkwin(n), (n == 0) || (n == 2), relu(W'(n)), 1'b0, 1'b0);
    @(posedge i_clk); #1;
    pif.pool_input_data_valid = 1'b0;
    #1;
    i_rst = 1'b1;
    #1;
    chk("midrst_data", pif.o_pooled_data, '0);
    chk("midrst_valid", W'(pif.o_pooled_valid), '0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    run_frame(1'b0);
    idle(6);

    total++;
    if (q.size() == 0) pass++;
    else $display("FAIL queue_drain act=%0d pending exp=0", q.size());

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
